// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - encodes symbolic MIPS instructions and writes them sequentially into instruction memory
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        in_last,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [15:0] word_count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state;
    logic        last_q;
    logic        legal;
    logic [31:0] enc;

    always_comb begin
        legal = 1'b1;
        enc   = 32'h0000_0000;
        case (in_op)
            4'd0:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100000};
            4'd1:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100010};
            4'd2:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100100};
            4'd3:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100101};
            4'd4:  enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
            4'd5:  enc = {6'b100011, in_rs, in_rt, in_imm};
            4'd6:  enc = {6'b101011, in_rs, in_rt, in_imm};
            4'd7:  enc = {6'b000100, in_rs, in_rt, in_imm};
            4'd8:  enc = {6'b000101, in_rs, in_rt, in_imm};
            4'd9:  enc = {6'b000010, in_target};
            4'd10: enc = 32'h0000_0000;
            default: legal = 1'b0;
        endcase
    end

    // Handshake and status strobes are pure decodes of the state register.
    assign in_ready = (state == LOAD);
    assign mem_we   = (state == WRITE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_q     <= 1'b0;
            mem_addr   <= 32'h0000_0000;
            mem_wdata  <= 32'h0000_0000;
            word_count <= 16'd0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_count <= 16'd0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (legal) begin
                            mem_wdata <= enc;
                            mem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
                            last_q    <= in_last;
                            state     <= WRITE;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    word_count <= word_count + 16'd1;
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (({1'b0, word_count} + 17'd1) == MAX_W) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Assembles symbolic instructions into 32-bit MIPS words, the inverse of the pipeline control decoder, and writes them sequentially into instruction memory.
- Used by the testbench and boot path to load programs without a hex file.
- Accepts one instruction per valid/ready handshake, encodes it, and issues one word write per instruction.
- Raises done or err when loading ends.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word. Must be word aligned.
- MAX_WORDS, 256, capacity in words. Legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a load session
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept an instruction
- in_op  input  4  mnemonic: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 bne, 9 j, 10 nop; 11-15 illegal
- in_rs  input  5  source register
- in_rt  input  5  second source or destination register
- in_rd  input  5  R-type destination register
- in_imm  input  16  immediate or branch offset, passed through unmodified
- in_target  input  26  jump target field
- in_last  input  1  this instruction ends the program
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  32  byte address of the write
- mem_wdata  output  32  encoded instruction word
- word_count  output  16  words written this session
- busy  output  1  session in progress
- done  output  1  sticky, session completed
- err  output  1  sticky, illegal op or capacity exhausted

Behaviour:
- Reset (asynchronous): state IDLE. All of the following are 0: in_ready, mem_we, mem_addr, mem_wdata, word_count, busy, done, err.
- Reset mid-session aborts immediately. No further writes occur.
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.
- Encoding fields:
  - R-type word is {6'b000000, rs, rt, rd, 5'b00000, func}.
  - func values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
  - I-type word is {opcode, rs, rt, imm}.
  - I-type opcodes: lw 100011, sw 101011, beq 000100, bne 000101.
  - j word is {000010, target}.
  - nop is 32'h0000_0000.
  - Fields unused by an op are ignored.
- State IDLE:
  - in_ready=0, busy=0.
  - On start: word_count←0, done←0, err←0, go to LOAD.
- State LOAD:
  - in_ready=1, busy=1.
  - On in_valid & in_ready with a legal op: latch mem_wdata←encoding, mem_addr←BASE_ADDR + 4·word_count, latch in_last, go to WRITE.
  - On an illegal op: err←1, go to IDLE. Nothing is written.
- State WRITE:
  - mem_we=1 for exactly this one cycle; in_ready=0.
  - word_count increments at the end of the cycle.
  - If latched last=1: done←1, go to IDLE.
  - Else if word_count+1 == MAX_WORDS: done←1, err←1, go to IDLE (capacity exhausted).
  - Else go to LOAD.
- Throughput: one instruction per 2 cycles. Latency from the accepting edge to the mem_we cycle is 1 cycle.
- start while busy is ignored.
- start in IDLE clears done and err and restarts from BASE_ADDR.
- mem_addr and mem_wdata hold their last value after the session ends.
- in_valid while in_ready=0 is ignored; the source must hold its fields until accepted.

Test Plan:
- Reset, start, then add rs=1 rt=2 rd=3 with last=1 → one mem_we pulse, mem_addr=0x0, mem_wdata=0x00221820. Afterwards done=1, err=0, word_count=1, busy=0.
- Back-to-back stream with in_valid held high: lw rs=29 rt=8 imm=4; sw rs=0 rt=5 imm=8; beq rs=1 rt=2 imm=0xFFFF; j target=0x10 with last=1.
  - Writes: 0x8FA80004@0x0, 0xAC050008@0x4, 0x1022FFFF@0x8, 0x08000010@0xC.
  - in_ready is low on every WRITE cycle; word_count ends at 4.
- Illegal op 12 as the second instruction → only one write occurs. err=1, done=0, state returns to IDLE. A following start clears err.
- MAX_WORDS=2, three instructions offered with no last → two writes at 0x0 and 0x4. done=1 and err=1; the third instruction is never accepted.
- Assert rst during a WRITE cycle → mem_we drops asynchronously, all outputs return to 0. A new start reloads from BASE_ADDR.
- start pulse issued during LOAD → ignored: word_count and mem_addr sequence continue unchanged.
